// File: rtl/track_result_sync.sv
// Frame-synchronous holder for tracker box results feeding the box overlay.
// Optional build macro TRK_CLAMP_EN clamps incoming boxes to the active image at transfer.
`timescale 1ns/1ps
module track_result_sync #(
   parameter int IMG_WIDTH   = 1280,
   parameter int IMG_HEIGHT  = 720,
   parameter int HOLD_FRAMES = 8
) (
   input  logic        hdmi_pclk,
   input  logic        s_rst_n,
   input  logic        hdmi_vs,
   input  logic        trk_valid,
   output logic        trk_ready,
   input  logic        trk_lost,
   input  logic [15:0] trk_x,
   input  logic [15:0] trk_y,
   input  logic [15:0] trk_w,
   input  logic [15:0] trk_h,
   output logic [15:0] result_x,
   output logic [15:0] result_y,
   output logic [15:0] result_w,
   output logic [15:0] result_h,
   output logic        hdmi_vs_sel,
   output logic [7:0]  frame_age
);

   typedef enum logic {IDLE, SHOW} state_t;

   generate
      if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255 || IMG_WIDTH < 1 || IMG_HEIGHT < 1) begin : g_bad_param
         $error("track_result_sync: parameter out of range");
      end
   endgenerate

   state_t      state_reg;
   logic        vs_d1_reg;
   logic        pending_reg;
   logic [15:0] shadow_x_reg, shadow_y_reg, shadow_w_reg, shadow_h_reg;
   logic        shadow_lost_reg;

   logic        vs_rise;
   logic        transfer;
   logic        lost_in;
   logic [7:0]  age_inc;

   // Axis 0 = horizontal (x/w), axis 1 = vertical (y/h)
   logic [15:0] pos_in  [2];
   logic [15:0] len_in  [2];
   logic [15:0] pos_st  [2];
   logic [15:0] len_st  [2];

   assign pos_in[0] = trk_x;
   assign pos_in[1] = trk_y;
   assign len_in[0] = trk_w;
   assign len_in[1] = trk_h;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
`ifdef TRK_CLAMP_EN
         localparam logic [16:0] P_MAX = 17'((gi == 0) ? IMG_WIDTH - 1 : IMG_HEIGHT - 1);
         logic [16:0] p_ext, l_ext, p_c, room, l_c;
         always_comb begin
            p_ext = {1'b0, pos_in[gi]};
            l_ext = {1'b0, len_in[gi]};
            p_c   = (p_ext > P_MAX) ? P_MAX : p_ext;
            room  = P_MAX - p_c;
            l_c   = (l_ext > room) ? room : l_ext;
         end
         assign pos_st[gi] = p_c[15:0];
         assign len_st[gi] = l_c[15:0];
`else
         assign pos_st[gi] = pos_in[gi];
         assign len_st[gi] = len_in[gi];
`endif
      end
   endgenerate

   assign vs_rise   = hdmi_vs & ~vs_d1_reg;
   assign trk_ready = ~pending_reg;
   assign transfer  = trk_valid & ~pending_reg;
   // A zero-size box is treated the same as an explicit loss report
   assign lost_in   = trk_lost | (len_st[0] == 16'd0) | (len_st[1] == 16'd0);
   assign age_inc   = (frame_age == 8'hFF) ? 8'hFF : frame_age + 8'd1;

   always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_reg       <= IDLE;
         vs_d1_reg       <= 1'b0;
         pending_reg     <= 1'b0;
         shadow_x_reg    <= '0;
         shadow_y_reg    <= '0;
         shadow_w_reg    <= '0;
         shadow_h_reg    <= '0;
         shadow_lost_reg <= 1'b0;
         result_x        <= '0;
         result_y        <= '0;
         result_w        <= '0;
         result_h        <= '0;
         hdmi_vs_sel     <= 1'b0;
         frame_age       <= '0;
      end else begin
         vs_d1_reg <= hdmi_vs;

         if (transfer) begin
            shadow_x_reg    <= pos_st[0];
            shadow_y_reg    <= pos_st[1];
            shadow_w_reg    <= len_st[0];
            shadow_h_reg    <= len_st[1];
            shadow_lost_reg <= lost_in;
            pending_reg     <= 1'b1;
         end

         // transfer requires pending=0, so it never collides with the clear below
         if (vs_rise) begin
            if (pending_reg) begin
               pending_reg <= 1'b0;
               if (!shadow_lost_reg) begin
                  result_x    <= shadow_x_reg;
                  result_y    <= shadow_y_reg;
                  result_w    <= shadow_w_reg;
                  result_h    <= shadow_h_reg;
                  frame_age   <= 8'd0;
                  state_reg   <= SHOW;
                  hdmi_vs_sel <= 1'b1;
               end else begin
                  frame_age   <= age_inc;
                  state_reg   <= IDLE;
                  hdmi_vs_sel <= 1'b0;
               end
            end else begin
               frame_age <= age_inc;
               if (state_reg == SHOW && age_inc == 8'(HOLD_FRAMES)) begin
                  state_reg   <= IDLE;
                  hdmi_vs_sel <= 1'b0;
               end
            end
         end
      end
   end

endmodule
